pll_reconfig_ctrl: RTL

//  Controls the PLL's control/dynamic-ratio port (pll_rst, pll_pwd, dyn_idiv/fdiv/odiv0/odiv1) and consumes pll_lock.

---
 rtl/pll_reconfig_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/pll_reconfig_ctrl.sv
// PLL reset/lock sequencer with run-time ratio reconfiguration.
// Runs on the free-running board clock. It holds the PLL in reset, waits for
// lock with a timeout and bounded retries, and qualifies lock stability before
// it raises clk_ok. New divider ratios are loaded through a valid/ready
// handshake, and each load forces a fresh reset/lock cycle.
module pll_reconfig_ctrl #(
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_TIMEOUT = 65535,
  parameter int         LOCK_STABLE  = 256,
  parameter int         MAX_RETRY    = 3,
  parameter logic [9:0] DEF_IDIV     = 10'd5,
  parameter logic [9:0] DEF_FDIV     = 10'd72,
  parameter logic [9:0] DEF_ODIV0    = 10'd30,
  parameter logic [9:0] DEF_ODIV1    = 10'd80
) (
  input  logic       clkin1,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [9:0] cfg_idiv,
  input  logic [9:0] cfg_fdiv,
  input  logic [9:0] cfg_odiv0,
  input  logic [9:0] cfg_odiv1,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       pll_pwd,
  output logic [9:0] dyn_idiv,
  output logic [9:0] dyn_fdiv,
  output logic [9:0] dyn_odiv0,
  output logic [9:0] dyn_odiv1,
  output logic       clk_ok,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       lock_lost,
  output logic       failed
);

  localparam int MAX_AB  = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int MAX_CNT = (MAX_AB > RST_CYCLES) ? MAX_AB : RST_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int RW      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_RESET, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAIL
  } state_t;

  state_t        state, state_nxt;
  logic          lock_m, lock_s;
  logic [CW-1:0] rst_cnt, rst_cnt_nxt;
  logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [CW-1:0] stab_cnt, stab_cnt_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic          load_cfg, cfg_rej;
  logic          accept, cfg_zero, timeout;

  assign accept   = cfg_valid && cfg_ready;
  assign cfg_zero = (cfg_idiv == '0) || (cfg_fdiv == '0) ||
                    (cfg_odiv0 == '0) || (cfg_odiv1 == '0);
  assign timeout  = (tmo_cnt == CW'(LOCK_TIMEOUT - 1));

  // Status decoded straight from the state register.
  assign cfg_ready = ((state == S_RUN) && lock_s) || (state == S_FAIL);
  assign pll_rst   = (state == S_RESET) || (state == S_FAIL);
  assign pll_pwd   = 1'b0;
  assign busy      = (state == S_RESET) || (state == S_WAIT_LOCK) || (state == S_STABLE);
  assign failed    = (state == S_FAIL);
  // Lock loss is flagged in the same cycle the synced lock drops. Leaving RUN
  // makes it a single-cycle pulse.
  assign lock_lost = (state == S_RUN) && !lock_s;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clkin1) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // Next-state logic for the sequencer: counter updates, retry and cfg decisions.
  always_comb begin
    state_nxt    = state;
    rst_cnt_nxt  = rst_cnt;
    tmo_cnt_nxt  = tmo_cnt;
    stab_cnt_nxt = stab_cnt;
    retry_nxt    = retry;
    load_cfg     = 1'b0;
    cfg_rej      = 1'b0;
    case (state)
      S_RESET: begin
        if (rst_cnt >= CW'(RST_CYCLES - 1)) begin
          state_nxt   = S_WAIT_LOCK;
          rst_cnt_nxt = '0;
          tmo_cnt_nxt = '0;
        end else begin
          rst_cnt_nxt = rst_cnt + CW'(1);
        end
      end
      S_WAIT_LOCK, S_STABLE: begin
        tmo_cnt_nxt = tmo_cnt + CW'(1);
        if (timeout) begin
          // Timeout wins over any lock transition in the same cycle.
          if (retry < RW'(MAX_RETRY)) begin
            retry_nxt   = retry + RW'(1);
            state_nxt   = S_RESET;
            rst_cnt_nxt = '0;
          end else begin
            state_nxt = S_FAIL;
          end
        end else if (state == S_WAIT_LOCK) begin
          if (lock_s) begin
            // The cycle that first sees lock counts toward stability.
            state_nxt    = S_STABLE;
            stab_cnt_nxt = CW'(1);
          end
        end else if (!lock_s) begin
          state_nxt    = S_WAIT_LOCK;
          stab_cnt_nxt = '0;
        end else if (stab_cnt >= CW'(LOCK_STABLE - 1)) begin
          state_nxt = S_RUN;
        end else begin
          stab_cnt_nxt = stab_cnt + CW'(1);
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          // The PLL relocks on its own, so there is no pll_rst here.
          state_nxt   = S_WAIT_LOCK;
          tmo_cnt_nxt = '0;
          retry_nxt   = '0;
        end else if (accept) begin
          if (cfg_zero) begin
            cfg_rej = 1'b1;
          end else begin
            load_cfg    = 1'b1;
            retry_nxt   = '0;
            state_nxt   = S_RESET;
            rst_cnt_nxt = '0;
          end
        end
      end
      S_FAIL: begin
        if (accept) begin
          if (cfg_zero) begin
            cfg_rej = 1'b1;
          end else begin
            load_cfg    = 1'b1;
            retry_nxt   = '0;
            state_nxt   = S_RESET;
            rst_cnt_nxt = '0;
          end
        end
      end
      default: state_nxt = S_RESET;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clkin1) begin
    if (!rst_n) begin
      state    <= S_RESET;
      rst_cnt  <= '0;
      tmo_cnt  <= '0;
      stab_cnt <= '0;
      retry    <= '0;
    end else begin
      state    <= state_nxt;
      rst_cnt  <= rst_cnt_nxt;
      tmo_cnt  <= tmo_cnt_nxt;
      stab_cnt <= stab_cnt_nxt;
      retry    <= retry_nxt;
    end
  end

  // Ratio registers. They load only while entering RESET, so pll_rst is high as they change.
  always_ff @(posedge clkin1) begin
    if (!rst_n) begin
      dyn_idiv  <= DEF_IDIV;
      dyn_fdiv  <= DEF_FDIV;
      dyn_odiv0 <= DEF_ODIV0;
      dyn_odiv1 <= DEF_ODIV1;
    end else if (load_cfg) begin
      dyn_idiv  <= cfg_idiv;
      dyn_fdiv  <= cfg_fdiv;
      dyn_odiv0 <= cfg_odiv0;
      dyn_odiv1 <= cfg_odiv1;
    end
  end

  // Registered clk_ok level and done/err pulses, each aligned to the state it reports.
  always_ff @(posedge clkin1) begin
    if (!rst_n) begin
      clk_ok <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      clk_ok <= (state_nxt == S_RUN);
      done   <= (state_nxt == S_RUN) && (state != S_RUN);
      err    <= cfg_rej || ((state_nxt == S_FAIL) && (state != S_FAIL));
    end
  end

endmodule
